wb_pipe_stage: RTL and testbench

Parametrised writeback pipeline register chain for the 64-bit ARM pipeline, the generalised replacement for the fixed single-stage MEM/WB flop bank. Carries a valid bit, register-write enable, destination register and write data through `STAGES` register stages with pipeline-wide stall and stage-0 flush. Suppresses writes to the zero register. Provides `NUM_LOOKUP` forwarding ports that return the youngest in-flight write to a requested register.

---
 rtl/wb_pipe_stage.sv | 125 ++++++++++++
 tb/tb_wb_pipe_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_stage.sv
// Writeback pipeline register chain.
// Carries {valid, reg_wr, rd, data} through STAGES register stages, with a
// pipeline-wide stall and a stage-0 flush. The chain never writes the zero
// register. It also provides NUM_LOOKUP forwarding ports that return the
// youngest in-flight write to a requested register.
module wb_pipe_stage #(
    parameter int DATA_W     = 64,
    parameter int REG_W      = 5,
    parameter int STAGES     = 1,
    parameter int NUM_LOOKUP = 2,
    parameter int ZERO_REG   = 31
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic                         in_reg_wr,
    input  logic [REG_W-1:0]             in_rd,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    output logic                         out_reg_wr,
    output logic [REG_W-1:0]             out_rd,
    output logic [DATA_W-1:0]            out_data,
    input  logic [NUM_LOOKUP*REG_W-1:0]  lookup_rd,
    output logic [NUM_LOOKUP-1:0]        lookup_hit,
    output logic [NUM_LOOKUP*DATA_W-1:0] lookup_data
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    // Stage 0 is the youngest stage. Stage STAGES-1 drives the out_* ports.
    logic              valid_q [STAGES];
    logic              wr_q    [STAGES];
    logic [REG_W-1:0]  rd_q    [STAGES];
    logic [DATA_W-1:0] data_q  [STAGES];

    logic              valid_d [STAGES];
    logic              wr_d    [STAGES];
    logic [REG_W-1:0]  rd_d    [STAGES];
    logic [DATA_W-1:0] data_d  [STAGES];

    // Next state: hold by default, advance when not stalled. Flush overrides
    // stage 0 even under stall, so a stalled bubble can still be injected.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            valid_d[i] = valid_q[i];
            wr_d[i]    = wr_q[i];
            rd_d[i]    = rd_q[i];
            data_d[i]  = data_q[i];
        end
        if (!stall) begin
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                wr_d[i]    = wr_q[i-1];
                rd_d[i]    = rd_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
        if (flush) begin
            valid_d[0] = 1'b0;
            wr_d[0]    = 1'b0;
            rd_d[0]    = '0;
            data_d[0]  = '0;
        end else if (!stall) begin
            valid_d[0] = in_valid;
            wr_d[0]    = in_valid & in_reg_wr & (in_rd != ZERO_IDX);
            rd_d[0]    = in_rd;
            data_d[0]  = in_data;
        end
    end

    // Stage registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                wr_q[i]    <= 1'b0;
                rd_q[i]    <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= valid_d[i];
                wr_q[i]    <= wr_d[i];
                rd_q[i]    <= rd_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign out_reg_wr = valid_q[STAGES-1] & wr_q[STAGES-1];
    assign out_rd     = rd_q[STAGES-1];
    assign out_data   = data_q[STAGES-1];

    // The forwarding ports read only the stage registers, never in_*.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LOOKUP; gi++) begin : g_lookup
            logic [REG_W-1:0]  src_rd;
            logic              fwd_hit;
            logic [DATA_W-1:0] fwd_data;

            assign src_rd = lookup_rd[gi*REG_W +: REG_W];

            // Scan from the oldest stage to the youngest so that the youngest match wins.
            always_comb begin
                fwd_hit  = 1'b0;
                fwd_data = '0;
                for (int s = STAGES - 1; s >= 0; s--) begin
                    if (valid_q[s] && wr_q[s] && (rd_q[s] == src_rd) &&
                        (src_rd != ZERO_IDX)) begin
                        fwd_hit  = 1'b1;
                        fwd_data = data_q[s];
                    end
                end
            end

            assign lookup_hit[gi]                   = fwd_hit;
            assign lookup_data[gi*DATA_W +: DATA_W] = fwd_data;
        end
    endgenerate

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Testbench for wb_pipe_stage with STAGES=2.
// Runs a directed sequence, then a randomized sequence. A reference model
// holds two stage entries and checks every output after each clock edge.
module tb_wb_pipe_stage;

    localparam int DW = 64;
    localparam int RW = 5;
    localparam int NS = 2;
    localparam int NL = 2;

    logic          clk = 1'b0;
    logic          reset, stall, flush;
    logic          in_valid, in_reg_wr;
    logic [RW-1:0] in_rd;
    logic [DW-1:0] in_data;
    logic          out_valid, out_reg_wr;
    logic [RW-1:0] out_rd;
    logic [DW-1:0] out_data;
    logic [NL*RW-1:0] lookup_rd;
    logic [NL-1:0]    lookup_hit;
    logic [NL*DW-1:0] lookup_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          v;
        logic          w;
        logic [RW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    // Reference pipeline. Index 0 is the youngest entry.
    ent_t m [NS];

    wb_pipe_stage #(.DATA_W(DW), .REG_W(RW), .STAGES(NS), .NUM_LOOKUP(NL), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_wr(in_reg_wr), .in_rd(in_rd), .in_data(in_data),
        .out_valid(out_valid), .out_reg_wr(out_reg_wr), .out_rd(out_rd), .out_data(out_data),
        .lookup_rd(lookup_rd), .lookup_hit(lookup_hit), .lookup_data(lookup_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Search the in-flight entries from youngest to oldest for a valid write to r.
    task automatic ref_lookup(input logic [RW-1:0] r, output logic hit, output logic [DW-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (r != 5'd31) begin
            for (int s = 0; s < NS; s++) begin
                if (!hit && m[s].v && m[s].w && m[s].rd == r) begin
                    hit  = 1'b1;
                    data = m[s].d;
                end
            end
        end
    endtask

    task automatic compare_lookups();
        logic          h;
        logic [DW-1:0] d;
        for (int k = 0; k < NL; k++) begin
            ref_lookup(lookup_rd[k*RW +: RW], h, d);
            chk($sformatf("lookup_hit[%0d]", k), DW'(lookup_hit[k]), DW'(h));
            chk($sformatf("lookup_data[%0d]", k), lookup_data[k*DW +: DW], d);
        end
    endtask

    task automatic compare_all();
        chk("out_valid", DW'(out_valid), DW'(m[NS-1].v));
        chk("out_reg_wr", DW'(out_reg_wr), DW'(m[NS-1].v & m[NS-1].w));
        chk("out_rd", DW'(out_rd), DW'(m[NS-1].rd));
        chk("out_data", out_data, m[NS-1].d);
        compare_lookups();
    endtask

    // Apply one clock edge, update the model with the sampled inputs, then compare.
    task automatic step();
        logic s_rst, s_stall, s_flush, s_v, s_w;
        logic [RW-1:0] s_rd;
        logic [DW-1:0] s_d;
        @(posedge clk);
        s_rst = reset; s_stall = stall; s_flush = flush;
        s_v = in_valid; s_w = in_reg_wr; s_rd = in_rd; s_d = in_data;
        if (!s_rst) begin
            for (int s = 0; s < NS; s++) m[s] = '0;
        end else begin
            if (!s_stall) begin
                for (int s = NS - 1; s > 0; s--) m[s] = m[s-1];
            end
            if (s_flush) m[0] = '0;
            else if (!s_stall) m[0] = '{s_v, s_v & s_w & (s_rd != 5'd31), s_rd, s_d};
        end
        #1;
        compare_all();
        $display("cycle rst=%0b stall=%0b flush=%0b in=%0b/%0b/%0d/%h out=%0b/%0b/%0d/%h hit=%b",
                 s_rst, s_stall, s_flush, s_v, s_w, s_rd, s_d,
                 out_valid, out_reg_wr, out_rd, out_data, lookup_hit);
    endtask

    task automatic drive(input logic v, input logic w, input logic [RW-1:0] r, input logic [DW-1:0] d);
        in_valid = v; in_reg_wr = w; in_rd = r; in_data = d;
    endtask

    task automatic set_lookup(input logic [RW-1:0] p0, input logic [RW-1:0] p1);
        lookup_rd = {p1, p0};
        #1;
        compare_lookups();
    endtask

    initial begin
        for (int s = 0; s < NS; s++) m[s] = '0;
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b0, 5'd3, 64'hAA);
        lookup_rd = {5'd3, 5'd3};

        // Step 1: reset behaviour, then a write that takes two edges to reach the output.
        step(); step();
        chk("rst_out_valid", DW'(out_valid), 64'd0);
        chk("rst_hits", DW'(lookup_hit), 64'd0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 64'hAA);
        step();
        chk("lat1_out_reg_wr", DW'(out_reg_wr), 64'd0);
        drive(1'b0, 1'b0, 5'd0, 64'd0);
        step();
        chk("lat2_out_reg_wr", DW'(out_reg_wr), 64'd1);
        chk("lat2_out_rd", DW'(out_rd), 64'd3);
        chk("lat2_out_data", out_data, 64'hAA);

        // Step 2: the youngest of two writes to the same register is forwarded.
        set_lookup(5'd5, 5'd0);
        drive(1'b1, 1'b1, 5'd5, 64'h11); step();
        drive(1'b1, 1'b1, 5'd5, 64'h22); step();
        chk("fwd_young_hit", DW'(lookup_hit[0]), 64'd1);
        chk("fwd_young_data", lookup_data[63:0], 64'h22);
        drive(1'b0, 1'b0, 5'd0, 64'd0); step();
        chk("fwd_old_data", lookup_data[63:0], 64'h22);

        // Step 3: a write to the zero register is suppressed.
        set_lookup(5'd0, 5'd31);
        drive(1'b1, 1'b1, 5'd31, 64'hFF); step();
        chk("xzr_hit_s0", DW'(lookup_hit[1]), 64'd0);
        drive(1'b0, 1'b0, 5'd0, 64'd0); step();
        chk("xzr_out_valid", DW'(out_valid), 64'd1);
        chk("xzr_out_reg_wr", DW'(out_reg_wr), 64'd0);
        chk("xzr_hit_s1", DW'(lookup_hit[1]), 64'd0);

        // Step 4: stall holds every stage, and input presented under stall is dropped.
        drive(1'b1, 1'b1, 5'd7, 64'h33); step();
        set_lookup(5'd7, 5'd8);
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd8, 64'h44);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hit7", DW'(lookup_hit[0]), 64'd1);
            chk("stall_data7", lookup_data[63:0], 64'h33);
            chk("stall_hit8", DW'(lookup_hit[1]), 64'd0);
        end
        stall = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 64'd0);

        // Step 5: stall together with flush bubbles stage 0 while stage 1 holds.
        drive(1'b1, 1'b1, 5'd9, 64'h99); step();
        set_lookup(5'd9, 5'd7);
        chk("pre_flush_hit9", DW'(lookup_hit[0]), 64'd1);
        stall = 1'b1; flush = 1'b1; step();
        chk("flush_hit9", DW'(lookup_hit[0]), 64'd0);
        chk("flush_s1_rd", DW'(out_rd), 64'd7);
        stall = 1'b0; flush = 1'b0;

        // Step 6: reset in the middle of the stream discards all in-flight entries.
        set_lookup(5'd4, 5'd6);
        drive(1'b1, 1'b1, 5'd4, 64'h10); step();
        drive(1'b1, 1'b1, 5'd6, 64'h20); step();
        chk("full_hits", DW'(lookup_hit), 64'd3);
        reset = 1'b0; step();
        chk("midrst_out_valid", DW'(out_valid), 64'd0);
        chk("midrst_hits", DW'(lookup_hit), 64'd0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_wr", DW'(out_reg_wr), 64'd0);
        end

        // Randomized traffic with a small register range so that forwarding hits are frequent.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) >= 3);
            stall = ($urandom_range(0, 99) < 20);
            flush = ($urandom_range(0, 99) < 10);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5)),
                  {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0)
                set_lookup(($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5)),
                           5'($urandom_range(0, 5)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
